// File: rtl/video_pkg.sv
// Shared definitions for the video pattern source: pattern codes, the
// colour-bar palette, RGB field packing and the source FSM state type.
package video_pkg;

  localparam int RGB_W = 24;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_SOLID = 2'd1;
  localparam logic [1:0] PAT_RAMP  = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  // Colour bars, left to right
  localparam logic [RGB_W-1:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [RGB_W-1:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [RGB_W-1:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [RGB_W-1:0] BAR_RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [RGB_W-1:0] BAR_BLACK   = 24'h000000;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } src_state_e;

  // Pack three 8-bit channels into the stream pixel layout
  function automatic logic [RGB_W-1:0] rgb(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    logic [RGB_W-1:0] p;
    p = '0;
    p[R_LSB +: 8] = r;
    p[G_LSB +: 8] = g;
    p[B_LSB +: 8] = b;
    return p;
  endfunction

  function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
    logic [RGB_W-1:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_raster_counter.sv
// Raster position tracker: x/y pixel counters plus a bar index driven by an
// in-bar counter, so the colour-bar index needs no divider. The counters
// describe the pixel currently presented; the *_nxt outputs give the position
// that will be presented after this clock edge (equal to the current one
// when advance is low).
module video_raster_counter
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [15:0] x_nxt,
  output logic [15:0] y_nxt,
  output logic [2:0]  bar_nxt,
  output logic        sof_nxt,
  output logic        eol_nxt,
  output logic        eof
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [15:0] H_LAST   = 16'(H_ACTIVE - 1);
  localparam logic [15:0] V_LAST   = 16'(V_ACTIVE - 1);
  localparam logic [15:0] BAR_LAST = 16'(BAR_W - 1);

  logic [15:0] x_q, y_q, in_bar_q;
  logic [2:0]  bar_q;
  logic [15:0] x_n, y_n, in_bar_n;
  logic [2:0]  bar_n;
  logic        eol;

  assign eol = (x_q == H_LAST);
  assign eof = eol && (y_q == V_LAST);

  // Next-position logic; the last bar keeps counting so it absorbs the remainder
  always_comb begin
    x_n      = x_q;
    y_n      = y_q;
    bar_n    = bar_q;
    in_bar_n = in_bar_q;
    if (advance) begin
      if (eol) begin
        x_n      = '0;
        bar_n    = '0;
        in_bar_n = '0;
        y_n      = (y_q == V_LAST) ? '0 : y_q + 16'd1;
      end else begin
        x_n = x_q + 16'd1;
        if ((in_bar_q == BAR_LAST) && (bar_q != 3'd7)) begin
          bar_n    = bar_q + 3'd1;
          in_bar_n = '0;
        end else begin
          in_bar_n = in_bar_q + 16'd1;
        end
      end
    end
  end

  // Position registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      bar_q    <= '0;
      in_bar_q <= '0;
    end else begin
      x_q      <= x_n;
      y_q      <= y_n;
      bar_q    <= bar_n;
      in_bar_q <= in_bar_n;
    end
  end

  assign x_nxt   = x_n;
  assign y_nxt   = y_n;
  assign bar_nxt = bar_n;
  assign sof_nxt = (x_n == 16'd0) && (y_n == 16'd0);
  assign eol_nxt = (x_n == H_LAST);

endmodule

// File: rtl/axis_video_pattern_src.sv
// AXI4-Stream video pattern source. Streams whole active-video frames of
// 24-bit RGB test patterns; TUSER marks start of frame, TLAST end of line.
// The pattern is latched only at frame boundaries and frames are never cut
// short except by reset.
//
// Handshake: a beat transfers on a clock edge where M_AXIS_TVALID and
// M_AXIS_TREADY are both 1. Once TVALID is raised, TVALID/TDATA/TUSER/TLAST
// hold unchanged until that transfer; TVALID never depends on TREADY.
module axis_video_pattern_src
  import video_pkg::*;
#(
  parameter int H_ACTIVE             = 1280,
  parameter int V_ACTIVE             = 720,
  parameter int C_M_AXIS_TDATA_WIDTH = 24,
  parameter int CHECKER_LOG2         = 5
) (
  input  logic                            M_AXIS_ACLK,
  input  logic                            M_AXIS_ARESET,
  input  logic                            enable,
  input  logic [1:0]                      pattern_sel,
  input  logic [RGB_W-1:0]                solid_color,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic                            M_AXIS_TLAST,
  output logic                            M_AXIS_TUSER,
  output logic                            busy,
  output logic                            frame_done,
  output logic [15:0]                     frame_count,
  output src_state_e                      state_dbg
);

  src_state_e       state;
  logic [1:0]       pat_q;
  logic [RGB_W-1:0] solid_q;
  logic [RGB_W-1:0] tdata_q;
  logic             tvalid_q, tuser_q, tlast_q, busy_q, frame_done_q;
  logic [15:0]      frame_cnt_q;

  logic             accept, latch;
  logic [1:0]       pat_eff;
  logic [RGB_W-1:0] solid_eff, pix_nxt;
  logic [15:0]      x_nxt, y_nxt;
  logic [2:0]       bar_nxt;
  logic             sof_nxt, eol_nxt, eof;

  assign accept = tvalid_q && M_AXIS_TREADY;
  // Pattern is (re)latched when a frame is about to begin
  assign latch = enable && ((state == ST_IDLE) || (accept && eof));
  assign pat_eff   = latch ? pattern_sel : pat_q;
  assign solid_eff = latch ? solid_color : solid_q;

  video_raster_counter #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE)
  ) u_raster (
    .clk    (M_AXIS_ACLK),
    .rst    (M_AXIS_ARESET),
    .advance(accept),
    .x_nxt  (x_nxt),
    .y_nxt  (y_nxt),
    .bar_nxt(bar_nxt),
    .sof_nxt(sof_nxt),
    .eol_nxt(eol_nxt),
    .eof    (eof)
  );

  function automatic logic [RGB_W-1:0] pixel_color(input logic [1:0] pat,
                                                   input logic [RGB_W-1:0] solid,
                                                   input logic [15:0] x,
                                                   input logic [15:0] y,
                                                   input logic [2:0] bar);
    logic [RGB_W-1:0] c;
    case (pat)
      PAT_BARS:  c = bar_color(bar);
      PAT_SOLID: c = solid;
      PAT_RAMP:  c = rgb(x[7:0], x[7:0], x[7:0]);
      PAT_CHECK: c = (x[CHECKER_LOG2] ^ y[CHECKER_LOG2]) ? BAR_WHITE : BAR_BLACK;
      default:   c = BAR_BLACK;
    endcase
    return c;
  endfunction

  // Colour of the pixel that will be presented after this edge
  assign pix_nxt = pixel_color(pat_eff, solid_eff, x_nxt, y_nxt, bar_nxt);

  // Source FSM with registered stream outputs
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state        <= ST_IDLE;
      pat_q        <= '0;
      solid_q      <= '0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tuser_q      <= 1'b0;
      tlast_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            pat_q    <= pattern_sel;
            solid_q  <= solid_color;
            state    <= ST_STREAM;
            busy_q   <= 1'b1;
            tvalid_q <= 1'b1;
            tdata_q  <= pix_nxt;
            tuser_q  <= sof_nxt;
            tlast_q  <= eol_nxt;
          end
        end
        ST_STREAM: begin
          if (accept) begin
            if (eof) begin
              frame_done_q <= 1'b1;
              if (enable) begin
                pat_q    <= pattern_sel;
                solid_q  <= solid_color;
                tdata_q  <= pix_nxt;
                tuser_q  <= sof_nxt;
                tlast_q  <= eol_nxt;
              end else begin
                state    <= ST_IDLE;
                busy_q   <= 1'b0;
                tvalid_q <= 1'b0;
                tdata_q  <= '0;
                tuser_q  <= 1'b0;
                tlast_q  <= 1'b0;
              end
            end else begin
              tdata_q <= pix_nxt;
              tuser_q <= sof_nxt;
              tlast_q <= eol_nxt;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Completed-frame counter, wraps naturally at 16 bits
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      frame_cnt_q <= '0;
    end else if (accept && eof) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TUSER  = tuser_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign frame_count   = frame_cnt_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_axis_video_pattern_src.sv
// Directed bench for axis_video_pattern_src: a 16x4 instance for frame,
// backpressure, pattern-switch, reset and wrap cases, and a 20x1 instance
// for the colour-bar remainder case.
module tb_axis_video_pattern_src;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: 16x4
  logic        enable, tready, tvalid, tlast, tuser, busy, frame_done;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_color, tdata;
  logic [15:0] frame_count;
  video_pkg::src_state_e state_dbg;

  // DUT B: 20x1 colour bars
  logic        enable_b, tready_b, tvalid_b, tlast_b, tuser_b, busy_b, frame_done_b;
  logic [1:0]  pattern_sel_b;
  logic [23:0] solid_color_b, tdata_b;
  logic [15:0] frame_count_b;
  video_pkg::src_state_e state_dbg_b;

  axis_video_pattern_src #(
    .H_ACTIVE(16), .V_ACTIVE(4), .C_M_AXIS_TDATA_WIDTH(24), .CHECKER_LOG2(2)
  ) dut_a (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst), .enable(enable),
    .pattern_sel(pattern_sel), .solid_color(solid_color),
    .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready),
    .M_AXIS_TLAST(tlast), .M_AXIS_TUSER(tuser), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count), .state_dbg(state_dbg)
  );

  axis_video_pattern_src #(
    .H_ACTIVE(20), .V_ACTIVE(1), .C_M_AXIS_TDATA_WIDTH(24), .CHECKER_LOG2(5)
  ) dut_b (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst), .enable(enable_b),
    .pattern_sel(pattern_sel_b), .solid_color(solid_color_b),
    .M_AXIS_TDATA(tdata_b), .M_AXIS_TVALID(tvalid_b), .M_AXIS_TREADY(tready_b),
    .M_AXIS_TLAST(tlast_b), .M_AXIS_TUSER(tuser_b), .busy(busy_b),
    .frame_done(frame_done_b), .frame_count(frame_count_b), .state_dbg(state_dbg_b)
  );

  // Scoreboard: {tuser, tlast, tdata}
  logic [25:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference pixel for the 16x4 instance (bar width 2, checker square 4)
  function automatic logic [23:0] exp_pixel(input int pat, input logic [23:0] solid,
                                            input int x, input int y);
    int b;
    logic [7:0] xv;
    xv = 8'(x);
    case (pat)
      0: begin
        b = x / 2;
        if (b > 7) b = 7;
        return bars[b];
      end
      1: return solid;
      2: return {xv, xv, xv};
      default: return ((((x >> 2) ^ (y >> 2)) & 1) == 1) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic push_frame(input int pat, input logic [23:0] solid);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 16; x++)
        exp_q.push_back({(x == 0 && y == 0), (x == 15), exp_pixel(pat, solid, x, y)});
  endtask

  // Driver: one-cycle enable pulse to start a single frame
  task automatic start_frame(input logic [1:0] pat, input logic [23:0] solid);
    pattern_sel = pat;
    solid_color = solid;
    enable = 1'b1;
    step();
    enable = 1'b0;
  endtask

  // Accept nbeats beats, comparing each against the scoreboard and checking
  // that stalled beats hold steady. cycles counts clocks spent.
  task automatic collect(input int nbeats, input bit rand_ready, output int got,
                         output int cycles);
    logic [26:0] prev;
    bit stalled;
    logic [25:0] e;
    got = 0;
    cycles = 0;
    stalled = 0;
    prev = '0;
    while (got < nbeats && cycles < 4000) begin
      if (stalled) check("stall_hold", 32'({tvalid, tuser, tlast, tdata}), 32'(prev));
      tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tvalid) begin
        if (tready) begin
          if (exp_q.size() == 0) begin
            check("exp_q_underflow", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("beat", 32'({tuser, tlast, tdata}), 32'(e));
          end
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          prev = {tvalid, tuser, tlast, tdata};
        end
      end else begin
        stalled = 0;
      end
      step();
      cycles++;
    end
    if (got < nbeats) check("collect_timeout", 32'(got), 32'(nbeats));
  endtask

  int got, cyc, cyc_total, blacks;

  initial begin
    enable = 0; pattern_sel = 0; solid_color = 0; tready = 1;
    enable_b = 0; pattern_sel_b = 0; solid_color_b = 0; tready_b = 1;
    rst = 1;
    repeat (3) step();

    // Reset state
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_tdata", 32'(tdata), 0);
    check("rst_tuser", 32'(tuser), 0);
    check("rst_tlast", 32'(tlast), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    check("rst_state", 32'(state_dbg), 32'(video_pkg::ST_IDLE));
    check("rst_b_tvalid", 32'(tvalid_b), 0);
    rst = 0;
    step();

    // Single colour-bar frame, enable pulsed, TREADY high
    push_frame(0, 24'h0);
    start_frame(2'd0, 24'h0);
    check("t1_busy", 32'(busy), 1);
    check("t1_state", 32'(state_dbg), 32'(video_pkg::ST_STREAM));
    collect(64, 0, got, cyc);
    check("t1_beats", 32'(got), 64);
    check("t1_cycles", 32'(cyc), 64);
    check("t1_frame_done", 32'(frame_done), 1);
    check("t1_frame_count", 32'(frame_count), 1);
    check("t1_tvalid_after", 32'(tvalid), 0);
    check("t1_busy_after", 32'(busy), 0);
    step();
    check("t1_frame_done_pulse", 32'(frame_done), 0);
    check("t1_tvalid_idle", 32'(tvalid), 0);

    // 20-pixel line: bar width 2, last bar covers pixels 14..19
    enable_b = 1;
    step();
    enable_b = 0;
    blacks = 0;
    for (int x = 0; x < 20; x++) begin
      check("b_tvalid", 32'(tvalid_b), 1);
      check("b_tdata", 32'(tdata_b), 32'((x < 14) ? bars[x / 2] : 24'h000000));
      check("b_tlast", 32'(tlast_b), 32'(x == 19));
      check("b_tuser", 32'(tuser_b), 32'(x == 0));
      if (tdata_b == 24'h000000) blacks++;
      step();
    end
    check("b_black_pixels", 32'(blacks), 6);
    check("b_frame_done", 32'(frame_done_b), 1);
    check("b_frame_count", 32'(frame_count_b), 1);
    check("b_busy_after", 32'(busy_b), 0);
    check("b_state_after", 32'(state_dbg_b), 32'(video_pkg::ST_IDLE));

    // Ramp under random backpressure
    push_frame(2, 24'h0);
    start_frame(2'd2, 24'h0);
    collect(64, 1, got, cyc);
    check("t3_beats", 32'(got), 64);
    check("t3_frame_done", 32'(frame_done), 1);
    check("t3_frame_count", 32'(frame_count), 2);
    check("t3_tvalid_after", 32'(tvalid), 0);
    tready = 1;
    step();

    // Back-to-back frames, pattern switched mid-frame, enable dropped in frame 3
    push_frame(1, 24'h123456);
    push_frame(3, 24'h0);
    push_frame(3, 24'h0);
    pattern_sel = 2'd1;
    solid_color = 24'h123456;
    enable = 1;
    step();
    collect(32, 0, got, cyc);
    cyc_total = cyc;
    pattern_sel = 2'd3;
    solid_color = 24'hABCDEF;
    collect(32, 0, got, cyc);
    cyc_total += cyc;
    check("t4_f1_frame_done", 32'(frame_done), 1);
    check("t4_f1_frame_count", 32'(frame_count), 3);
    check("t4_f2_sof_no_gap", 32'({tvalid, tuser}), 32'b11);
    collect(64, 0, got, cyc);
    cyc_total += cyc;
    check("t4_f2_frame_done", 32'(frame_done), 1);
    check("t4_f2_frame_count", 32'(frame_count), 4);
    collect(10, 0, got, cyc);
    cyc_total += cyc;
    enable = 0;
    collect(54, 0, got, cyc);
    cyc_total += cyc;
    check("t4_total_cycles", 32'(cyc_total), 192);
    check("t4_f3_frame_count", 32'(frame_count), 5);
    check("t4_tvalid_after", 32'(tvalid), 0);
    step();

    // Reset during a stalled beat aborts the frame
    push_frame(0, 24'h0);
    start_frame(2'd0, 24'h0);
    collect(30, 0, got, cyc);
    tready = 0;
    rst = 1;
    step();
    exp_q.delete();
    check("t5_tvalid", 32'(tvalid), 0);
    check("t5_tdata", 32'(tdata), 0);
    check("t5_tuser", 32'(tuser), 0);
    check("t5_tlast", 32'(tlast), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_frame_done", 32'(frame_done), 0);
    check("t5_frame_count", 32'(frame_count), 0);
    rst = 0;
    pattern_sel = 2'd0;
    enable = 1;
    step();
    enable = 0;
    check("t5_restart_sof", 32'({tvalid, tuser, tlast, tdata}), 32'({3'b110, 24'hFFFFFF}));
    push_frame(0, 24'h0);
    collect(64, 0, got, cyc);
    check("t5_frame_count", 32'(frame_count), 1);
    step();

    // frame_count wrap
    force dut_a.frame_cnt_q = 16'hFFFF;
    step();
    release dut_a.frame_cnt_q;
    check("t6_preload", 32'(frame_count), 32'hFFFF);
    push_frame(2, 24'h0);
    start_frame(2'd2, 24'h0);
    collect(64, 0, got, cyc);
    check("t6_frame_count_wrap", 32'(frame_count), 0);
    check("t6_frame_done", 32'(frame_done), 1);
    step();
    check("t6_frame_done_pulse", 32'(frame_done), 0);
    check("t6_exp_q_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
